// File: rtl/axi4_wr_arbiter_if.sv
// axi4_wr_arbiter_if: N upstream AXI4 write ports (packed per-master arrays) plus the one shared downstream port.
// The slave modport is the arbiter's view; master is the surrounding masters and memory-side slave.
interface axi4_wr_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ID_WIDTH    = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 64
);
   localparam int IDX_W = $clog2(NUM_MASTERS);
   logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]     s_aw_id;
   logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   s_aw_addr;
   logic [NUM_MASTERS-1:0][7:0]              s_aw_len;
   logic [NUM_MASTERS-1:0][2:0]              s_aw_size;
   logic [NUM_MASTERS-1:0][1:0]              s_aw_burst;
   logic [NUM_MASTERS-1:0][15:0]             s_aw_side;
   logic [NUM_MASTERS-1:0]                   s_aw_valid;
   logic [NUM_MASTERS-1:0]                   s_aw_ready;
   logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   s_w_data;
   logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] s_w_strb;
   logic [NUM_MASTERS-1:0]                   s_w_last;
   logic [NUM_MASTERS-1:0]                   s_w_valid;
   logic [NUM_MASTERS-1:0]                   s_w_ready;
   logic [ID_WIDTH-1:0]                      s_b_id;
   logic [1:0]                               s_b_resp;
   logic [NUM_MASTERS-1:0]                   s_b_valid;
   logic [NUM_MASTERS-1:0]                   s_b_ready;
   logic [ID_WIDTH+IDX_W-1:0]                m_aw_id;
   logic [ADDR_WIDTH-1:0]                    m_aw_addr;
   logic [7:0]                               m_aw_len;
   logic [2:0]                               m_aw_size;
   logic [1:0]                               m_aw_burst;
   logic [15:0]                              m_aw_side;
   logic                                     m_aw_valid;
   logic                                     m_aw_ready;
   logic [DATA_WIDTH-1:0]                    m_w_data;
   logic [DATA_WIDTH/8-1:0]                  m_w_strb;
   logic                                     m_w_last;
   logic                                     m_w_valid;
   logic                                     m_w_ready;
   logic [ID_WIDTH+IDX_W-1:0]                m_b_id;
   logic [1:0]                               m_b_resp;
   logic                                     m_b_valid;
   logic                                     m_b_ready;

   modport slave (
      input  s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_side, s_aw_valid,
      output s_aw_ready,
      input  s_w_data, s_w_strb, s_w_last, s_w_valid,
      output s_w_ready,
      output s_b_id, s_b_resp, s_b_valid,
      input  s_b_ready,
      output m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_side, m_aw_valid,
      input  m_aw_ready,
      output m_w_data, m_w_strb, m_w_last, m_w_valid,
      input  m_w_ready,
      input  m_b_id, m_b_resp, m_b_valid,
      output m_b_ready
   );

   modport master (
      output s_aw_id, s_aw_addr, s_aw_len, s_aw_size, s_aw_burst, s_aw_side, s_aw_valid,
      input  s_aw_ready,
      output s_w_data, s_w_strb, s_w_last, s_w_valid,
      input  s_w_ready,
      input  s_b_id, s_b_resp, s_b_valid,
      output s_b_ready,
      input  m_aw_id, m_aw_addr, m_aw_len, m_aw_size, m_aw_burst, m_aw_side, m_aw_valid,
      output m_aw_ready,
      input  m_w_data, m_w_strb, m_w_last, m_w_valid,
      output m_w_ready,
      output m_b_id, m_b_resp, m_b_valid,
      input  m_b_ready
   );
endinterface

// File: rtl/axi4_wr_arbiter.sv
// axi4_wr_arbiter: round-robin AW arbiter sharing one AXI4 write port; W follows AW order via an index FIFO,
// B is routed back by the master index carried in the upper downstream ID bits.
module axi4_wr_arbiter #(
   parameter int NUM_MASTERS  = 2,
   parameter int ID_WIDTH     = 4,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int W_FIFO_DEPTH = 4
) (
   input logic              aclk,
   input logic              arst_n,
   axi4_wr_arbiter_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_MASTERS);
   localparam int PW    = $clog2(W_FIFO_DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                  state, state_nx;
   logic [IDX_W-1:0]        rr_ptr, rr_nx, grant, grant_nx, pick, head, sel;
   logic [IDX_W:0]          k;
   logic [IDX_W-1:0]        fifo [W_FIFO_DEPTH];
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic [PW:0]             count;
   logic                    empty, full, push, pop, aw_hs, b_in;
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;

   assign empty = count == '0;
   assign full  = count == (PW+1)'(W_FIFO_DEPTH);
   assign head  = fifo[rd_ptr];

   // Cyclic search from rr_ptr: iterate from the far end so the nearest requester wins.
   always_comb begin
      pick = rr_ptr;
      k    = '0;
      for (int i = NUM_MASTERS-1; i >= 0; i--) begin
         k = {1'b0, rr_ptr} + (IDX_W+1)'(i);
         k = (k >= (IDX_W+1)'(NUM_MASTERS)) ? k - (IDX_W+1)'(NUM_MASTERS) : k;
         if (bus.s_aw_valid[k[IDX_W-1:0]]) pick = k[IDX_W-1:0];
      end
   end

   assign aw_hs = (state == HOLD) && bus.s_aw_valid[grant] && bus.m_aw_ready;

   always_comb begin
      state_nx       = state;
      grant_nx       = grant;
      rr_nx          = rr_ptr;
      push           = 1'b0;
      bus.m_aw_valid = 1'b0;
      bus.s_aw_ready = '0;
      if (state == IDLE) begin
         if (|bus.s_aw_valid && !full) begin
            grant_nx = pick;
            state_nx = HOLD;
         end
      end else begin
         bus.m_aw_valid        = bus.s_aw_valid[grant];
         bus.s_aw_ready[grant] = bus.m_aw_ready;
         if (aw_hs) begin
            push     = 1'b1;
            rr_nx    = (grant == IDX_W'(NUM_MASTERS-1)) ? '0 : grant + 1'b1;
            state_nx = IDLE;
         end
      end
   end

   assign aw_addr        = bus.s_aw_addr[grant];
   assign bus.m_aw_id    = {grant, bus.s_aw_id[grant]};
   assign bus.m_aw_addr  = aw_addr;
   assign bus.m_aw_len   = bus.s_aw_len[grant];
   assign bus.m_aw_size  = bus.s_aw_size[grant];
   assign bus.m_aw_burst = bus.s_aw_burst[grant];
   assign bus.m_aw_side  = bus.s_aw_side[grant];

   assign w_data        = bus.s_w_data[head];
   assign w_strb        = bus.s_w_strb[head];
   assign bus.m_w_data  = w_data;
   assign bus.m_w_strb  = w_strb;
   assign bus.m_w_last  = bus.s_w_last[head];
   assign bus.m_w_valid = !empty && bus.s_w_valid[head];
   assign bus.s_w_ready = empty ? '0 : NUM_MASTERS'(bus.m_w_ready) << head;
   assign pop           = bus.m_w_valid && bus.m_w_ready && bus.m_w_last;

   always_ff @(posedge aclk or negedge arst_n)
      if (!arst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         grant  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         state  <= state_nx;
         rr_ptr <= rr_nx;
         grant  <= grant_nx;
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + (PW+1)'(push) - (PW+1)'(pop);
      end

   always_ff @(posedge aclk)
      if (push) fifo[wr_ptr] <= grant;

   // B is purely combinational; gating with reset keeps every valid/ready low while held in reset.
   assign sel           = bus.m_b_id[ID_WIDTH+IDX_W-1:ID_WIDTH];
   assign b_in          = 32'(sel) < NUM_MASTERS;
   assign bus.s_b_valid = (arst_n && b_in && bus.m_b_valid) ? NUM_MASTERS'(1) << sel : '0;
   assign bus.m_b_ready = arst_n && (b_in ? bus.s_b_ready[sel] : 1'b1);
   assign bus.s_b_id    = bus.m_b_id[ID_WIDTH-1:0];
   assign bus.s_b_resp  = bus.m_b_resp;
endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// tb_axi4_wr_arbiter: directed AXI4 write-arbiter scenarios; a queue-based reference model is checked
// every cycle at the falling edge, plus hand-computed literal expectations for each scenario.
module tb_axi4_wr_arbiter;
   localparam int N = 2, IW = 4, AW = 32, DW = 64, D = 4, XW = 1;

   logic aclk = 1'b0;
   logic arst_n = 1'b0;
   int pass_n = 0;
   int total_n = 0;
   int n;
   logic [3:0] ord;
   bit holding = 1'b0;
   logic [XW-1:0] hold_idx = '0;
   logic [XW-1:0] rr = '0;
   logic [XW-1:0] q[$];

   axi4_wr_arbiter_if #(.NUM_MASTERS(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi4_wr_arbiter #(
      .NUM_MASTERS(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .W_FIFO_DEPTH(D)
   ) dut (
      .aclk(aclk),
      .arst_n(arst_n),
      .bus(bus)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total_n++;
      if (got === exp) pass_n++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic set_aw(input logic [XW-1:0] m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len);
      bus.s_aw_id[m]    = id;
      bus.s_aw_addr[m]  = addr;
      bus.s_aw_len[m]   = len;
      bus.s_aw_size[m]  = 3'd3;
      bus.s_aw_burst[m] = 2'b01;
      bus.s_aw_side[m]  = 16'h5A00 | 16'(addr[11:4]);
   endtask

   task automatic set_w(input logic [XW-1:0] m, input logic [DW-1:0] data, input logic last);
      bus.s_w_data[m] = data;
      bus.s_w_strb[m] = data[7:0];
      bus.s_w_last[m] = last;
   endtask

   task automatic rst_zero(input string tag);
      check({tag, "_m_aw_valid"}, 64'(bus.m_aw_valid), 64'(0));
      check({tag, "_s_aw_ready"}, 64'(bus.s_aw_ready), 64'(0));
      check({tag, "_s_w_ready"},  64'(bus.s_w_ready),  64'(0));
      check({tag, "_m_w_valid"},  64'(bus.m_w_valid),  64'(0));
      check({tag, "_s_b_valid"},  64'(bus.s_b_valid),  64'(0));
      check({tag, "_m_b_ready"},  64'(bus.m_b_ready),  64'(0));
   endtask

   // Reference model: a pending-grant slot, a round-robin start index and a queue of accepted bursts.
   always @(negedge aclk) begin : model
      logic [N-1:0] e_awr, e_wr, e_bv;
      logic e_awv, e_wv, e_br, full, b_in, found;
      logic [XW-1:0] head, sel, idx;
      if (!arst_n) begin
         holding = 1'b0;
         rr = '0;
         q.delete();
         rst_zero("mdl_rst");
      end else begin
         head  = (q.size() > 0) ? q[0] : '0;
         e_awv = holding && bus.s_aw_valid[hold_idx];
         e_awr = holding ? N'(bus.m_aw_ready) << hold_idx : '0;
         e_wv  = (q.size() > 0) && bus.s_w_valid[head];
         e_wr  = (q.size() > 0) ? N'(bus.m_w_ready) << head : '0;
         sel   = bus.m_b_id[IW+XW-1:IW];
         b_in  = int'(sel) < N;
         e_bv  = (b_in && bus.m_b_valid) ? N'(1) << sel : '0;
         e_br  = b_in ? bus.s_b_ready[sel] : 1'b1;
         check("m_aw_valid", 64'(bus.m_aw_valid), 64'(e_awv));
         check("s_aw_ready", 64'(bus.s_aw_ready), 64'(e_awr));
         if (e_awv) begin
            check("m_aw_id",    64'(bus.m_aw_id),    64'({hold_idx, bus.s_aw_id[hold_idx]}));
            check("m_aw_addr",  64'(bus.m_aw_addr),  64'(bus.s_aw_addr[hold_idx]));
            check("m_aw_len",   64'(bus.m_aw_len),   64'(bus.s_aw_len[hold_idx]));
            check("m_aw_size",  64'(bus.m_aw_size),  64'(bus.s_aw_size[hold_idx]));
            check("m_aw_burst", 64'(bus.m_aw_burst), 64'(bus.s_aw_burst[hold_idx]));
            check("m_aw_side",  64'(bus.m_aw_side),  64'(bus.s_aw_side[hold_idx]));
         end
         check("m_w_valid", 64'(bus.m_w_valid), 64'(e_wv));
         check("s_w_ready", 64'(bus.s_w_ready), 64'(e_wr));
         if (e_wv) begin
            check("m_w_data", bus.m_w_data, bus.s_w_data[head]);
            check("m_w_strb", 64'(bus.m_w_strb), 64'(bus.s_w_strb[head]));
            check("m_w_last", 64'(bus.m_w_last), 64'(bus.s_w_last[head]));
         end
         check("s_b_valid", 64'(bus.s_b_valid), 64'(e_bv));
         check("m_b_ready", 64'(bus.m_b_ready), 64'(e_br));
         if (bus.m_b_valid) begin
            check("s_b_id",   64'(bus.s_b_id),   64'(bus.m_b_id[IW-1:0]));
            check("s_b_resp", 64'(bus.s_b_resp), 64'(bus.m_b_resp));
         end
         // Advance to the state that holds after the coming rising edge.
         full = q.size() >= D;
         if (e_wv && bus.m_w_ready && bus.s_w_last[head]) void'(q.pop_front());
         if (holding && e_awv && bus.m_aw_ready) begin
            q.push_back(hold_idx);
            rr = XW'((int'(hold_idx) + 1) % N);
            holding = 1'b0;
         end else if (!holding && |bus.s_aw_valid && !full) begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
               idx = XW'((int'(rr) + i) % N);
               if (!found && bus.s_aw_valid[idx]) begin
                  hold_idx = idx;
                  found = 1'b1;
               end
            end
            holding = 1'b1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.s_aw_id = '0; bus.s_aw_addr = '0; bus.s_aw_len = '0; bus.s_aw_size = '0;
      bus.s_aw_burst = '0; bus.s_aw_side = '0; bus.s_aw_valid = '0;
      bus.s_w_data = '0; bus.s_w_strb = '0; bus.s_w_last = '0; bus.s_w_valid = '0;
      bus.s_b_ready = '0; bus.m_aw_ready = 1'b1; bus.m_w_ready = 1'b1;
      bus.m_b_id = '0; bus.m_b_resp = '0; bus.m_b_valid = 1'b0;
      repeat (2) @(negedge aclk);
      rst_zero("lit_reset");
      #1 arst_n = 1'b1;
      tick();

      // Single burst from master 0: AW one cycle after request, then four W beats in order.
      set_aw(0, 4'd3, 32'h1000, 8'd3);
      bus.s_aw_valid = 2'b01;
      @(negedge aclk);
      check("lit_aw_not_yet", 64'(bus.m_aw_valid), 64'(0));
      tick();
      @(negedge aclk);
      check("lit_aw_valid", 64'(bus.m_aw_valid), 64'(1));
      check("lit_aw_id",    64'(bus.m_aw_id),    64'h03);
      check("lit_aw_addr",  64'(bus.m_aw_addr),  64'h1000);
      check("lit_aw_len",   64'(bus.m_aw_len),   64'd3);
      tick();
      bus.s_aw_valid = '0;
      bus.s_w_valid = 2'b01;
      for (int b = 0; b < 4; b++) begin
         set_w(0, 64'hA0 + 64'(b), b == 3);
         @(negedge aclk);
         check("lit_w_beat_valid", 64'(bus.m_w_valid), 64'(1));
         check("lit_w_beat_data",  bus.m_w_data, 64'hA0 + 64'(b));
         tick();
      end
      @(negedge aclk);
      check("lit_fifo_empty_w_valid", 64'(bus.m_w_valid), 64'(0));
      check("lit_fifo_empty_w_ready", 64'(bus.s_w_ready), 64'(0));
      tick();
      bus.s_w_valid = '0;

      // Fresh reset, then both masters request continuously: grants must alternate 0,1,0,1.
      arst_n = 1'b0;
      tick();
      arst_n = 1'b1;
      set_aw(0, 4'd1, 32'h100, 8'd0);
      set_aw(1, 4'd2, 32'h200, 8'd0);
      set_w(0, 64'h10, 1'b1);
      set_w(1, 64'h11, 1'b1);
      bus.s_w_valid = 2'b11;
      bus.s_aw_valid = 2'b11;
      n = 0;
      ord = '0;
      for (int c = 0; c < 30 && n < 4; c++) begin
         @(negedge aclk);
         if (bus.m_aw_valid && bus.m_aw_ready) begin
            ord = {ord[2:0], bus.m_aw_id[IW]};
            n++;
         end
         tick();
      end
      bus.s_aw_valid = '0;
      check("lit_rr_count", 64'(n), 64'd4);
      check("lit_rr_order", 64'(ord), 64'b0101);
      tick();
      repeat (5) tick();
      bus.s_w_valid = '0;

      // Downstream stall: fields and grant must hold while master 1 also requests.
      bus.m_aw_ready = 1'b0;
      set_aw(0, 4'd7, 32'h2000, 8'd1);
      bus.s_aw_valid = 2'b01;
      tick();
      set_aw(1, 4'd1, 32'h3000, 8'd0);
      bus.s_aw_valid = 2'b11;
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         check("lit_stall_valid", 64'(bus.m_aw_valid), 64'(1));
         check("lit_stall_addr",  64'(bus.m_aw_addr),  64'h2000);
         check("lit_stall_id",    64'(bus.m_aw_id),    64'h07);
         tick();
      end
      bus.m_aw_ready = 1'b1;
      @(negedge aclk);
      check("lit_stall_release", 64'(bus.s_aw_ready), 64'b01);
      tick();
      bus.s_aw_valid = 2'b10;
      tick();
      @(negedge aclk);
      check("lit_m1_aw_id", 64'(bus.m_aw_id), 64'h11);
      tick();
      bus.s_aw_valid = '0;

      // W ordering: master 1 is blocked until master 0's earlier burst has its last beat.
      set_w(1, 64'hB1, 1'b1);
      bus.s_w_valid = 2'b10;
      @(negedge aclk);
      check("lit_order_ready", 64'(bus.s_w_ready), 64'b01);
      check("lit_order_valid", 64'(bus.m_w_valid), 64'(0));
      tick();
      set_w(0, 64'hC0, 1'b0);
      bus.s_w_valid = 2'b11;
      @(negedge aclk);
      check("lit_order_m0_data", bus.m_w_data, 64'hC0);
      tick();
      set_w(0, 64'hC1, 1'b1);
      tick();
      bus.s_w_valid = 2'b10;
      @(negedge aclk);
      check("lit_order_m1_ready", 64'(bus.s_w_ready), 64'b10);
      check("lit_order_m1_data",  bus.m_w_data, 64'hB1);
      tick();
      bus.s_w_valid = '0;

      // FIFO full: a fifth burst waits until one burst's last W beat frees an entry.
      set_aw(0, 4'd2, 32'h4000, 8'd0);
      set_w(0, 64'hD0, 1'b1);
      bus.s_aw_valid = 2'b01;
      n = 0;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge aclk);
         if (bus.m_aw_valid && bus.m_aw_ready) n++;
         tick();
      end
      check("lit_full_pushes", 64'(n), 64'd4);
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         check("lit_full_blocked", 64'(bus.m_aw_valid), 64'(0));
         tick();
      end
      bus.s_w_valid = 2'b01;
      @(negedge aclk);
      check("lit_full_w_drains", 64'(bus.m_w_valid), 64'(1));
      tick();
      bus.s_w_valid = '0;
      @(negedge aclk);
      check("lit_full_regrant_wait", 64'(bus.m_aw_valid), 64'(0));
      tick();
      @(negedge aclk);
      check("lit_full_regrant", 64'(bus.m_aw_valid), 64'(1));
      tick();
      bus.s_aw_valid = '0;
      bus.s_w_valid = 2'b01;
      repeat (4) tick();
      bus.s_w_valid = '0;

      // B routing by the prepended master index.
      bus.m_b_valid = 1'b1;
      bus.m_b_id = 5'h15;
      bus.m_b_resp = 2'b10;
      bus.s_b_ready = 2'b10;
      @(negedge aclk);
      check("lit_b_valid", 64'(bus.s_b_valid), 64'b10);
      check("lit_b_id",    64'(bus.s_b_id),    64'h5);
      check("lit_b_resp",  64'(bus.s_b_resp),  64'b10);
      check("lit_b_ready", 64'(bus.m_b_ready), 64'(1));
      tick();
      bus.s_b_ready = 2'b01;
      @(negedge aclk);
      check("lit_b_ready_other", 64'(bus.m_b_ready), 64'(0));
      tick();
      bus.m_b_id = 5'h03;
      @(negedge aclk);
      check("lit_b_valid_m0", 64'(bus.s_b_valid), 64'b01);
      check("lit_b_ready_m0", 64'(bus.m_b_ready), 64'(1));
      tick();

      // Reset in the middle of a burst clears everything immediately.
      set_aw(0, 4'd4, 32'h5000, 8'd3);
      bus.s_aw_valid = 2'b01;
      tick();
      tick();
      bus.s_aw_valid = '0;
      set_w(0, 64'hE0, 1'b0);
      bus.s_w_valid = 2'b01;
      bus.m_b_id = 5'h00;
      @(negedge aclk);
      check("lit_mid_burst_w", 64'(bus.m_w_valid), 64'(1));
      #1 arst_n = 1'b0;
      #1 rst_zero("lit_async_rst");
      @(negedge aclk);
      #1 arst_n = 1'b1;
      @(negedge aclk);
      check("lit_post_rst_w_valid", 64'(bus.m_w_valid), 64'(0));
      check("lit_post_rst_w_ready", 64'(bus.s_w_ready), 64'(0));
      tick();
      bus.s_w_valid = '0;
      bus.m_b_valid = 1'b0;
      repeat (2) tick();

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
